// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, stall, redirect,
// exception entry/return with EPC capture, and a halt state.
module pc_unit #(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_VEC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter int          INC        = 4,
  parameter int          ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic [WIDTH-1:0] epc,
  output logic             fetch_valid,
  output logic             misaligned,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] RESET_PC   = RESET_VEC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] EXC_PC     = EXC_VEC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  // Mask of the low PC bits that must be zero; empty when ALIGN_BITS is 0.
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] epc_r;
  logic             fetch_valid_r;
  state_t           state_r;
  logic [WIDTH-1:0] pc_inc_s;

  // Sequential successor and alignment flag follow the current pc.
  always_comb begin
    pc_inc_s   = pc_r + INC_W;
    misaligned = |(pc_r & ALIGN_MASK);
  end

  // Control FSM and PC/EPC registers; redirects outrank halt and stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      epc_r         <= '0;
      state_r       <= BOOT;
      fetch_valid_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r       <= RUN;
          fetch_valid_r <= 1'b1;
        end
        RUN: begin
          if (exc_req) begin
            epc_r <= pc_r;
            pc_r  <= EXC_PC;
          end else if (eret) begin
            pc_r <= epc_r;
          end else if (br_valid) begin
            pc_r <= br_target;
          end else if (halt_req) begin
            state_r       <= HALT;
            fetch_valid_r <= 1'b0;
          end else if (stall) begin
            pc_r <= pc_r;
          end else begin
            pc_r <= pc_inc_s;
          end
        end
        HALT: begin
          if (exc_req) begin
            epc_r         <= pc_r;
            pc_r          <= EXC_PC;
            state_r       <= RUN;
            fetch_valid_r <= 1'b1;
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          state_r       <= BOOT;
          fetch_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_r;
  assign pc_next_seq = pc_inc_s;
  assign epc         = epc_r;
  assign fetch_valid = fetch_valid_r;
  assign state       = state_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit default instance and a 16-bit
// instance (INC 2, one alignment bit) share the stimulus.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_valid, exc_req, eret, halt_req;
  logic [31:0] br_target;

  logic [31:0] pc_a, nseq_a, epc_a;
  logic        fv_a, mis_a;
  logic [1:0]  st_a;
  logic [15:0] pc_b, nseq_b, epc_b;
  logic        fv_b, mis_b;
  logic [1:0]  st_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_unit dut_a (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_target(br_target), .exc_req(exc_req), .eret(eret), .halt_req(halt_req),
    .pc(pc_a), .pc_next_seq(nseq_a), .epc(epc_a), .fetch_valid(fv_a),
    .misaligned(mis_a), .state(st_a)
  );

  pc_unit #(.WIDTH(16), .INC(2), .ALIGN_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_target(br_target[15:0]), .exc_req(exc_req), .eret(eret), .halt_req(halt_req),
    .pc(pc_b), .pc_next_seq(nseq_b), .epc(epc_b), .fetch_valid(fv_b),
    .misaligned(mis_b), .state(st_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; br_valid = 1'b0; exc_req = 1'b0; eret = 1'b0; halt_req = 1'b0;
    br_target = 32'h0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #2;
    check_val("a_rst_pc", pc_a, 32'h0000_3000);
    check_val("a_rst_epc", epc_a, 32'h0);
    check_val("a_rst_fv", {31'b0, fv_a}, 32'h0);
    check_val("a_rst_state", {30'b0, st_a}, 32'h0);
    tick();
    reset = 1'b0;
    check_val("a_boot_state", {30'b0, st_a}, 32'h0);
    check_val("a_boot_fv", {31'b0, fv_a}, 32'h0);
    tick();
    check_val("a_run_state", {30'b0, st_a}, 32'h1);
    check_val("a_run_fv", {31'b0, fv_a}, 32'h1);
    check_val("a_first_pc", pc_a, 32'h0000_3000);
    tick(); check_val("a_seq1", pc_a, 32'h0000_3004);
    tick(); check_val("a_seq2", pc_a, 32'h0000_3008);

    // Stall holds; redirect beats stall.
    stall = 1'b1;
    tick(); check_val("a_stall1", pc_a, 32'h0000_3008);
    tick(); check_val("a_stall2", pc_a, 32'h0000_3008);
    br_valid = 1'b1; br_target = 32'h0000_3100;
    tick(); check_val("a_br_over_stall", pc_a, 32'h0000_3100);
    stall = 1'b0; br_target = 32'h0000_3010;
    tick(); check_val("a_br_3010", pc_a, 32'h0000_3010);

    // Exception round trip.
    br_valid = 1'b0; exc_req = 1'b1;
    tick();
    check_val("a_exc_pc", pc_a, 32'h0000_4180);
    check_val("a_exc_epc", epc_a, 32'h0000_3010);
    exc_req = 1'b0;
    tick(); check_val("a_hdl1", pc_a, 32'h0000_4184);
    tick(); check_val("a_hdl2", pc_a, 32'h0000_4188);
    eret = 1'b1;
    tick(); check_val("a_eret", pc_a, 32'h0000_3010);
    eret = 1'b0;

    // Priority: exception over eret and branch.
    br_valid = 1'b1; br_target = 32'h0000_3020;
    tick(); check_val("a_br_3020", pc_a, 32'h0000_3020);
    exc_req = 1'b1; eret = 1'b1; br_target = 32'h0000_3200;
    tick();
    check_val("a_prio_pc", pc_a, 32'h0000_4180);
    check_val("a_prio_epc", epc_a, 32'h0000_3020);
    exc_req = 1'b0; eret = 1'b0; br_target = 32'h0000_3102;
    tick();
    check_val("a_mis_pc", pc_a, 32'h0000_3102);
    check_val("a_mis_flag", {31'b0, mis_a}, 32'h1);
    check_val("a_mis_nseq", nseq_a, 32'h0000_3106);

    // Halt: everything except exc_req ignored.
    br_target = 32'h0000_3040;
    tick();
    check_val("a_br_3040", pc_a, 32'h0000_3040);
    check_val("a_aligned", {31'b0, mis_a}, 32'h0);
    br_valid = 1'b0; halt_req = 1'b1;
    tick();
    check_val("a_halt_state", {30'b0, st_a}, 32'h2);
    check_val("a_halt_fv", {31'b0, fv_a}, 32'h0);
    br_target = 32'h0000_5000;
    for (int i = 0; i < 5; i++) begin
      stall = i[0]; br_valid = ~i[0]; eret = 1'b1;
      tick();
      check_val("a_halt_pc", pc_a, 32'h0000_3040);
      check_val("a_halt_hold", {30'b0, st_a}, 32'h2);
    end
    idle(); exc_req = 1'b1;
    tick();
    check_val("a_hexc_state", {30'b0, st_a}, 32'h1);
    check_val("a_hexc_fv", {31'b0, fv_a}, 32'h1);
    check_val("a_hexc_pc", pc_a, 32'h0000_4180);
    check_val("a_hexc_epc", epc_a, 32'h0000_3040);

    // Wrap-around.
    exc_req = 1'b0; br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    check_val("a_top_pc", pc_a, 32'hFFFF_FFFC);
    check_val("a_top_nseq", nseq_a, 32'h0);
    br_valid = 1'b0;
    tick(); check_val("a_wrap", pc_a, 32'h0);

    // Asynchronous reset mid-cycle during a branch.
    br_valid = 1'b1; br_target = 32'h0000_5550;
    #3 reset = 1'b1;
    #1;
    check_val("a_areset_pc", pc_a, 32'h0000_3000);
    check_val("a_areset_state", {30'b0, st_a}, 32'h0);
    check_val("a_areset_fv", {31'b0, fv_a}, 32'h0);
    check_val("a_areset_epc", epc_a, 32'h0);
    tick();
    check_val("a_areset_hold", pc_a, 32'h0000_3000);

    // 16-bit instance: INC 2, one alignment bit.
    idle();
    reset = 1'b0;
    check_val("b_boot_pc", {16'b0, pc_b}, 32'h3000);
    check_val("b_boot_fv", {31'b0, fv_b}, 32'h0);
    tick();
    check_val("b_run_pc", {16'b0, pc_b}, 32'h3000);
    check_val("b_run_fv", {31'b0, fv_b}, 32'h1);
    tick(); check_val("b_seq1", {16'b0, pc_b}, 32'h3002);
    tick(); check_val("b_seq2", {16'b0, pc_b}, 32'h3004);
    br_valid = 1'b1; br_target = 32'h0000_3101;
    tick();
    check_val("b_mis_pc", {16'b0, pc_b}, 32'h3101);
    check_val("b_mis_flag", {31'b0, mis_b}, 32'h1);
    check_val("b_mis_nseq", {16'b0, nseq_b}, 32'h3103);
    br_target = 32'h0000_FFFE;
    tick();
    check_val("b_top_nseq", {16'b0, nseq_b}, 32'h0);
    br_valid = 1'b0;
    tick(); check_val("b_wrap", {16'b0, pc_b}, 32'h0);
    exc_req = 1'b1;
    tick();
    check_val("b_exc_pc", {16'b0, pc_b}, 32'h4180);
    check_val("b_exc_epc", {16'b0, epc_b}, 32'h0);
    exc_req = 1'b0; br_valid = 1'b1; br_target = 32'h0000_1234;
    #3 reset = 1'b1;
    #1;
    check_val("b_areset_pc", {16'b0, pc_b}, 32'h3000);
    check_val("b_areset_state", {30'b0, st_b}, 32'h0);
    check_val("b_areset_fv", {31'b0, fv_b}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage. It holds the architectural fetch address and advances it by a fixed increment. It also handles pipeline stall, branch/jump redirect, exception entry with EPC capture, exception return, and a halt state. It drives the instruction-memory address and a fetch-valid qualifier consumed by the IF/ID pipeline register.

## Interface
Parameters:
- WIDTH, 32, address width in bits.
- RESET_VEC, 32'h0000_3000, PC value loaded on reset (truncated to WIDTH).
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low PC bits that must be zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC this cycle (hazard stall).
- br_valid  in  1  redirect request from decode/execute.
- br_target  in  WIDTH  redirect address.
- exc_req  in  1  take an exception this cycle.
- eret  in  1  return from exception to the saved EPC.
- halt_req  in  1  enter HALT (from RUN only).
- pc  out  WIDTH  current fetch address (registered).
- pc_next_seq  out  WIDTH  pc + INC, combinational, wraps mod 2^WIDTH.
- epc  out  WIDTH  saved exception PC (registered).
- fetch_valid  out  1  pc is a valid fetch this cycle (registered).
- misaligned  out  1  combinational; 1 when pc[ALIGN_BITS-1:0] != 0 and ALIGN_BITS > 0.
- state  out  2  00 BOOT, 01 RUN, 10 HALT.

## Operation
- Reset (async, asserted at any time, including mid-redirect): pc = RESET_VEC, epc = 0, state = BOOT, fetch_valid = 0. All outputs take these values immediately, without waiting for a clock edge.
- BOOT: a single cycle; the next edge goes to RUN with fetch_valid = 1 and pc unchanged (RESET_VEC is the first fetched address). All inputs are ignored in BOOT.
- RUN, next-PC priority (highest first):
  1. exc_req: epc <= pc, pc <= EXC_VEC.
  2. eret: pc <= epc.
  3. br_valid: pc <= br_target.
  4. halt_req: state <= HALT, pc held.
  5. stall: pc held.
  6. Otherwise: pc <= pc + INC.
- Redirects (exc_req, eret, br_valid) override stall. The redirecting unit is downstream of the stall source, so the redirect wins.
- HALT: pc held, fetch_valid = 0. In HALT:
  - exc_req performs exception entry (epc <= pc, pc <= EXC_VEC) and returns to RUN with fetch_valid = 1.
  - All other inputs are ignored.
- Arithmetic is unsigned modulo 2^WIDTH. For example, pc = 2^WIDTH − INC advances to 0, with no flag raised.
- br_target is loaded unmodified, even when misaligned. The misaligned output flags it so the fetch exception can be raised downstream. The unit never self-triggers an exception.
- Simultaneous exc_req and eret: the exception wins and epc is overwritten with the current pc.
- eret with epc = 0 after reset: pc <= 0. This is legal and not checked.

## Timing
- All state changes occur on the rising clk edge, except reset, which is asynchronous.
- Latency from any request input to a new pc is 1 cycle. pc_next_seq and misaligned follow pc within the same cycle.
- fetch_valid timing:
  - 0 in the reset cycle(s) and in BOOT.
  - 1 from the first RUN cycle onward.
  - Drops to 0 in the first HALT cycle, i.e. the edge after halt_req is sampled.
- epc updates on the same edge as the exception-entry pc load. It is readable through eret the following cycle.
- Reset release: the first rising edge after deassertion is the BOOT → RUN edge. Reset asserted during a cycle discards any pending request.

## Test plan
- Reset/boot: assert reset, release, run 3 edges with no requests -> pc = 0x3000 in BOOT (fetch_valid 0), then 0x3000 (valid), 0x3004, 0x3008.
- Stall vs branch: at pc = 0x3008, assert stall for 2 cycles -> pc holds 0x3008. Then stall = 1 with br_valid = 1 and br_target = 0x3100 -> pc = 0x3100 next cycle.
- Exception round trip: at pc = 0x3010, assert exc_req -> pc = 0x4180, epc = 0x3010. Two cycles later assert eret -> pc = 0x3010.
- Priority and misalignment: exc_req + eret + br_valid together at pc = 0x3020 -> pc = 0x4180, epc = 0x3020. Then br_target = 0x3102 -> pc = 0x3102, misaligned = 1.
- Halt and wrap: halt_req at pc = 0x3040 -> state HALT, fetch_valid 0, pc frozen across 5 cycles with stall/br_valid toggling. Then exc_req -> RUN, pc = 0x4180, epc = 0x3040. Branch to 0xFFFFFFFC -> pc = 0xFFFFFFFC, then 0x00000000.
- Async reset mid-operation: assert reset between edges during a br_valid cycle -> pc = 0x3000, state BOOT, fetch_valid 0 immediately, no edge required. Repeat the sequence with WIDTH = 16, INC = 2, ALIGN_BITS = 1.
